contador_nbit_desc: RTL
=======================

CONTADOR_NBIT_DESC -- requirements
Module: contador_nbit_desc

Interface
REQ-001 SHALL have parameter WIDTH, default 2; counter width in bits, legal range 2..16.
REQ-002 SHALL have parameter WRAP, default 1; 1 = wrap from 0 to MAX, 0 = halt at 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port en  input  1  count-enable; one decrement per enabled cycle.
REQ-006 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-007 SHALL have port load_val  input  WIDTH  value taken when load=1.
REQ-008 SHALL have port count  output  WIDTH  registered counter value.
REQ-009 SHALL have port zero  output  1  combinational; high when count==0.
REQ-010 SHALL have port tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-011 SHALL have port halted  output  1  registered; high while the FSM is in HALTED.

Function
REQ-012 MAX SHALL equal 2^WIDTH-1; all arithmetic SHALL be unsigned modulo 2^WIDTH.
REQ-013 The FSM SHALL have exactly two states, RUN and HALTED; halted SHALL be 1 only in HALTED.
REQ-014 Priority per edge SHALL be: reset low, then load, then en, then hold.
REQ-015 load=1 SHALL set count<=load_val on that edge and ignore en; state SHALL go to RUN; tc SHALL be 0 next cycle.
REQ-016 In RUN, en=1, load=0, count!=0: count<=count-1, with latency one edge.
REQ-017 tc SHALL be 1 for exactly the cycle after the edge where count decremented from 1 to 0, and 0 otherwise.
REQ-018 Loading 0 SHALL NOT assert tc.
REQ-019 In RUN with WRAP=1, en=1, and count==0, the block SHALL set count<=MAX, keep tc=0, and stay in RUN.
REQ-020 In RUN with WRAP=0, en=1, and count==0, count SHALL stay 0 and state SHALL go to HALTED.
REQ-021 In HALTED, en SHALL be ignored; count SHALL hold 0 and tc SHALL stay 0.
REQ-022 The only exits from HALTED SHALL be load (any load_val, including 0) and reset.
REQ-023 With en=0 and load=0, count, state and halted SHALL hold, and tc SHALL be 0.
REQ-024 HALTED SHALL be unreachable when WRAP=1.

Reset
REQ-025 On a rising edge with reset=0, regardless of en and load, the block SHALL set count<=MAX, tc<=0, state<=RUN, halted<=0.
REQ-026 Reset asserted mid-count SHALL abort the count; a tc due on that edge SHALL be suppressed.
REQ-027 Reset SHALL take effect only on the clock edge; asynchronous reset terms SHALL NOT be present.

Structure
REQ-028 The state enum (RUN, HALTED) and the WRAP mode constants SHALL reside in shared package contador_pkg.
REQ-029 The block SHALL be a single module; no sub-module is required.
REQ-030 The block SHALL be one registered state process plus one combinational next-state process.
REQ-031 The block SHALL contain no latches and no combinational path from inputs to count, tc or halted.

Verification (WIDTH=2)
REQ-032 Reset low for 1 edge, then en=1 for 5 edges: count SHALL be 3,2,1,0,3,2; tc SHALL be high only in the cycle count first reads 0.
REQ-033 WRAP=0, start at 3, en=1 for 5 edges: count SHALL be 2,1,0,0,0; halted SHALL rise in the cycle after the first enabled edge at 0; tc SHALL pulse once.
REQ-034 In HALTED, load=1 with load_val=2, then en=1: count SHALL be 2,1,0; halted SHALL fall after the load edge; tc SHALL pulse after 1->0.
REQ-035 With count=1, load=1, load_val=0, and en=1 on the same edge: count SHALL be 0 and tc SHALL stay 0.
REQ-036 Reset low on the edge where count goes 1->0: count SHALL be 3, tc SHALL be 0, and halted SHALL be 0.
REQ-037 With en=0 for 4 edges at count=2: count SHALL hold 2 and tc SHALL stay 0 throughout.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types and mode constants for the down-counter.
package contador_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam bit WRAP_ON  = 1'b1;
    localparam bit WRAP_OFF = 1'b0;

endpackage

// File: rtl/contador_nbit_desc.sv
// Loadable N-bit down-counter with terminal-count pulse and optional halt-at-zero mode.
// WRAP=1 rolls 0 over to MAX; WRAP=0 parks in HALTED until a load or reset.
module contador_nbit_desc
    import contador_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter bit WRAP  = WRAP_ON
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             halted
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            count_q <= MAX;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // tc defaults low so it can only be a single-cycle pulse after a 1->0 step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            state_d = RUN;
            count_d = load_val;
        end else if (en) begin
            case (state_q)
                RUN: begin
                    if (count_q != '0) begin
                        count_d = count_q - ONE;
                        tc_d    = (count_q == ONE);
                    end else if (WRAP) begin
                        count_d = MAX;
                    end else begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign halted = (state_q == HALTED);
    assign zero   = (count_q == '0);

endmodule
